// File: rtl/fmac_vc_rdy_gen.sv
// Transmit-side credit-return generator: counts per-VC buffer releases and
// issues R_RDY/VC_RDY primitives into the two-slot transmit word, with
// interval statistics of credits returned.
module fmac_vc_rdy_gen #(
    parameter int unsigned NUM_VC = 4,
    parameter int unsigned CNT_W  = 8,
    localparam int unsigned IdxW  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    release_ev,
    input  logic [IdxW-1:0]         release_vc_idx,
    input  logic [NUM_VC-1:0][15:0] reg_vc_id_tbl,
    input  logic [1:0]              slot_avail,
    input  logic                    reg_link_up_cnt_en,
    input  logic                    int_stats_latch_clr,
    output logic [1:0]              rdy_valid,
    output logic [1:0][15:0]        rdy_vc_id,
    output logic                    pending_ovf,
    output logic [31:0]             int_stats_rdycnt,
    output logic [CNT_W-1:0]        int_stats_maxpend
);

    logic [CNT_W-1:0] pending_q [NUM_VC];
    logic [CNT_W-1:0] pending_d [NUM_VC];
    logic [CNT_W:0]   sum_w     [NUM_VC];
    logic [IdxW-1:0]  rr_q, rr_d;
    logic             ovf_q, ovf_set;
    logic [1:0]       rdy_valid_q;
    logic [1:0][15:0] rdy_vc_id_q;
    logic [31:0]      rdy_acc_q, rdy_acc_d, rdycnt_q;
    logic [CNT_W-1:0] maxpend_acc_q, maxpend_acc_d, maxpend_q, cur_max;
    logic [32:0]      acc_sum;
    logic [1:0]       pop_cnt;

    logic             g0_vld, g1_vld, rel_hit;
    logic [IdxW-1:0]  g0_idx, g1_idx, start1;

    // (base + off) mod NUM_VC, for round-robin scanning
    function automatic logic [IdxW-1:0] wrap_idx(logic [IdxW-1:0] base, int unsigned off);
        return IdxW'((32'(base) + off) % NUM_VC);
    endfunction

    // Two-slot arbitration: slot 0 from rr_ptr, slot 1 after slot 0's winner
    always_comb begin
        g0_vld = 1'b0;
        g0_idx = '0;
        g1_vld = 1'b0;
        g1_idx = '0;
        if (slot_avail[0]) begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                if (!g0_vld && pending_q[wrap_idx(rr_q, k)] != '0) begin
                    g0_vld = 1'b1;
                    g0_idx = wrap_idx(rr_q, k);
                end
            end
        end
        start1 = g0_vld ? wrap_idx(g0_idx, 1) : rr_q;
        if (slot_avail[1]) begin
            for (int unsigned k = 0; k < NUM_VC; k++) begin
                // Slot 0's winner is reached last, and needs a second credit to repeat
                if (!g1_vld) begin
                    if (g0_vld && wrap_idx(start1, k) == g0_idx) begin
                        if (pending_q[wrap_idx(start1, k)] > CNT_W'(1)) begin
                            g1_vld = 1'b1;
                            g1_idx = wrap_idx(start1, k);
                        end
                    end else if (pending_q[wrap_idx(start1, k)] != '0) begin
                        g1_vld = 1'b1;
                        g1_idx = wrap_idx(start1, k);
                    end
                end
            end
        end
        if (g1_vld) begin
            rr_d = wrap_idx(g1_idx, 1);
        end else if (g0_vld) begin
            rr_d = wrap_idx(g0_idx, 1);
        end else begin
            rr_d = rr_q;
        end
    end

    // Pending counter next state: release adds, grants subtract, saturate at max
    always_comb begin
        rel_hit = release_ev && (32'(release_vc_idx) < NUM_VC);
        ovf_set = 1'b0;
        cur_max = '0;
        for (int unsigned i = 0; i < NUM_VC; i++) begin
            sum_w[i] = {1'b0, pending_q[i]}
                     + (CNT_W+1)'(rel_hit && 32'(release_vc_idx) == i)
                     - (CNT_W+1)'(g0_vld && 32'(g0_idx) == i)
                     - (CNT_W+1)'(g1_vld && 32'(g1_idx) == i);
            if (sum_w[i][CNT_W]) begin
                pending_d[i] = '1;
                ovf_set      = 1'b1;
            end else begin
                pending_d[i] = sum_w[i][CNT_W-1:0];
            end
            if (pending_q[i] > cur_max) begin
                cur_max = pending_q[i];
            end
        end
    end

    // Interval accumulators: saturating credit count and peak pending
    always_comb begin
        pop_cnt = {1'b0, rdy_valid_q[0]} + {1'b0, rdy_valid_q[1]};
        acc_sum = {1'b0, rdy_acc_q} + 33'(pop_cnt);
        if (int_stats_latch_clr) begin
            rdy_acc_d     = 32'(pop_cnt);
            maxpend_acc_d = cur_max;
        end else begin
            rdy_acc_d     = acc_sum[32] ? '1 : acc_sum[31:0];
            maxpend_acc_d = (cur_max > maxpend_acc_q) ? cur_max : maxpend_acc_q;
        end
    end

    // Credit state and registered grant outputs; link-up wipes everything in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_VC; i++) pending_q[i] <= '0;
            rr_q        <= '0;
            ovf_q       <= 1'b0;
            rdy_valid_q <= '0;
            rdy_vc_id_q <= '0;
        end else if (reg_link_up_cnt_en) begin
            for (int i = 0; i < NUM_VC; i++) pending_q[i] <= '0;
            rr_q        <= '0;
            ovf_q       <= 1'b0;
            rdy_valid_q <= '0;
            rdy_vc_id_q <= '0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) pending_q[i] <= pending_d[i];
            rr_q           <= rr_d;
            ovf_q          <= ovf_q | ovf_set;
            rdy_valid_q    <= {g1_vld, g0_vld};
            rdy_vc_id_q[0] <= g0_vld ? reg_vc_id_tbl[g0_idx] : 16'h0000;
            rdy_vc_id_q[1] <= g1_vld ? reg_vc_id_tbl[g1_idx] : 16'h0000;
        end
    end

    // Statistics registers; latched values hold between latch pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_acc_q     <= '0;
            rdycnt_q      <= '0;
            maxpend_acc_q <= '0;
            maxpend_q     <= '0;
        end else begin
            rdy_acc_q     <= rdy_acc_d;
            maxpend_acc_q <= maxpend_acc_d;
            if (int_stats_latch_clr) begin
                rdycnt_q  <= rdy_acc_q;
                maxpend_q <= maxpend_acc_q;
            end
        end
    end

    assign rdy_valid         = rdy_valid_q;
    assign rdy_vc_id         = rdy_vc_id_q;
    assign pending_ovf       = ovf_q;
    assign int_stats_rdycnt  = rdycnt_q;
    assign int_stats_maxpend = maxpend_q;

endmodule
